// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared definitions for the UART transmit path.
//   - uart_state_t     : transmitter state encoding (PARITY exists in the
//                        encoding even when the parity build option is off)
//   - UART_IDLE_LEVEL  : level of the serial line when nothing is sent
//   - UART_CLK_DIV_DEFAULT / UART_DATA_W_DEFAULT : default parameter values
//   - cnt_width()      : counter width for a 0..n-1 counter, never below 1
package uart_tx_fifo_pkg;

    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   UART_CLK_DIV_DEFAULT = 434;   // 50 MHz / 115200 baud
    localparam int   UART_DATA_W_DEFAULT  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter, 0..CLK_DIV-1.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-low reset
//   clear in   restarts the count at 0 on the next edge
//   tick  out  one-cycle pulse during the last cycle of each bit period
// Parameters: CLK_DIV (clock cycles per bit, >= 2).
module uart_baud_gen
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // A clear in the same cycle as the wrap wins, so a freshly started
    // period is never cut short.
    assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter draining a registered-read byte FIFO.
// Pops one word whenever the FIFO is non-empty and sends it as 8N1
// (start bit, FIFO_WIDTH data bits LSB first, stop bit).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset
//   fifo_empty in   FIFO empty flag
//   fifo_rd    out  one-cycle read strobe per word
//   fifo_data  in   FIFO read data, valid the cycle after fifo_rd
//   tx         out  serial line, idles high
//   busy       out  high while a word is fetched or sent
// Parameters: FIFO_WIDTH (data bits per frame), CLK_DIV (cycles per bit).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = UART_DATA_W_DEFAULT,
    parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy
);

    localparam int               BIT_W    = cnt_width(FIFO_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FIFO_WIDTH - 1);

    uart_state_t           state;
    logic [FIFO_WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  baud_clear;
    logic                  baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;

    function automatic logic even_parity(input logic [FIFO_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Restarting the bit timer in LOAD aligns the start bit to a full period.
    assign baud_clear = (state == ST_LOAD);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fifo_rd    <= 1'b0;
            tx         <= UART_IDLE_LEVEL;
            busy       <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            fifo_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= UART_IDLE_LEVEL;
                    if (!fifo_empty) begin
                        state   <= ST_FETCH;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                // Read strobe is on the wire during this cycle; data follows.
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_reg  <= fifo_data;
                    bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= even_parity(fifo_data);
`endif
                    tx         <= 1'b0;
                    state      <= ST_START;
                end
                // tx always shows the bit that the shift register just gave up,
                // so shift_reg[0] is the next bit to send at each boundary.
                ST_START: begin
                    if (baud_tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= UART_IDLE_LEVEL;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx    <= UART_IDLE_LEVEL;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= UART_IDLE_LEVEL;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at CLK_DIV=4.
// A behavioural registered-read FIFO feeds the DUT; a line receiver decodes
// tx into frames which are compared against expected bit sequences.
module tb_uart_tx_fifo;

    localparam int W     = 8;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FRAME = NB * DIV;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // 8N1 samples in time order, bit i = sample i
        logic       par;     // even parity of data
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        int          fall;
    } rx_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd;
    logic [7:0] fifo_data  = 8'h00;
    logic       tx;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] fq[$];
    int   rd_cnt       = 0;
    int   rd_empty_cnt = 0;
    int   rd_double    = 0;
    logic prev_rd      = 1'b0;

    rx_t frames[$];
    int  falls         = 0;
    int  rd_neg_cyc    = 0;
    int  busy_fall_cyc = 0;

    vec_t       tbl[7];
    logic [7:0] b2b[3];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .FIFO_WIDTH (W),
        .CLK_DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO: data appears the cycle after the strobe.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (fifo_rd === 1'b1) begin
            rd_cnt++;
            if (prev_rd) rd_double++;
            if (fq.size() == 0) rd_empty_cnt++;
            else fifo_data <= fq.pop_front();
        end
        prev_rd = (fifo_rd === 1'b1);
        fifo_empty <= (fq.size() == 0);
    end

    // Line receiver: finds the falling start edge, samples mid-bit.
    initial begin
        logic prev_tx;
        logic prev_busy;
        logic active;
        int   n;
        rx_t  cur;
        prev_tx   = 1'b1;
        prev_busy = 1'b0;
        active    = 1'b0;
        n         = 0;
        cur.bits  = '0;
        cur.fall  = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                active    = 1'b0;
                prev_tx   = 1'b1;
                prev_busy = 1'b0;
            end else begin
                if (fifo_rd === 1'b1) rd_neg_cyc = cyc;
                if (prev_busy && busy === 1'b0) busy_fall_cyc = cyc;
                prev_busy = (busy === 1'b1);
                if (!active) begin
                    if (prev_tx && tx === 1'b0) begin
                        active   = 1'b1;
                        n        = 0;
                        cur.bits = '0;
                        cur.fall = cyc;
                        falls++;
                    end
                    prev_tx = (tx !== 1'b0);
                end else begin
                    n++;
                    if (n % DIV == DIV / 2) begin
                        cur.bits[n / DIV] = tx;
                        if (n / DIV == NB - 1) begin
                            frames.push_back(cur);
                            active  = 1'b0;
                            prev_tx = tx;
                        end
                    end
                end
            end
        end
    end

    // Reference frame from the byte value: start 0, data LSB first,
    // optional even parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int          v;
        int          ones;
        f    = '0;
        v    = int'(d);
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            f[k + 1] = ((v / (1 << k)) % 2) == 1;
            ones += (v / (1 << k)) % 2;
        end
`ifdef UART_TX_PARITY_EN
        f[9]  = (ones % 2) == 1;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [10:0] table_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (frames.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (frames.size() >= n);
    endtask

    initial begin
        bit         ok;
        rx_t        r;
        int         rd0;
        int         rde0;
        int         f0;
        int         t;
        int         bad_tx;
        int         bad_busy;
        logic [7:0] b;

        tbl[0] = '{8'h67, 10'b1011001110, 1'b1};
        tbl[1] = '{8'h4d, 10'b1010011010, 1'b0};
        tbl[2] = '{8'hef, 10'b1111011110, 1'b1};
        tbl[3] = '{8'h01, 10'b1000000010, 1'b1};
        tbl[4] = '{8'h00, 10'b1000000000, 1'b0};
        tbl[5] = '{8'hff, 10'b1111111110, 1'b0};
        tbl[6] = '{8'ha5, 10'b1101001010, 1'b0};
        b2b[0] = 8'h4d;
        b2b[1] = 8'hef;
        b2b[2] = 8'h01;

        // Reset held, then idle with an empty FIFO
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        rst = 1'b1;
        bad_tx   = 0;
        bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle_tx", 32'(bad_tx), 32'd0);
        check("idle_busy", 32'(bad_busy), 32'd0);
        check("idle_rd", 32'(rd_cnt), 32'd0);

        // Single-word vectors
        for (int i = 0; i < 7; i++) begin
            frames.delete();
            rd0 = rd_cnt;
            @(negedge clk);
            fq.push_back(tbl[i].data);
            wait_frames(1, FRAME * 3, ok);
            check($sformatf("vec%0d_timeout", i), 32'(ok), 32'd1);
            repeat (6) @(negedge clk);
            if (ok) begin
                r = frames.pop_front();
                check($sformatf("vec%0d_bits", i), 32'(r.bits), 32'(table_frame(tbl[i])));
                check($sformatf("vec%0d_rd_to_tx", i), 32'(r.fall - rd_neg_cyc), 32'd2);
                check($sformatf("vec%0d_busy_len", i), 32'(busy_fall_cyc - r.fall), 32'(FRAME));
            end
            check($sformatf("vec%0d_rd_count", i), 32'(rd_cnt - rd0), 32'd1);
            check($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'd1);
            check($sformatf("vec%0d_busy_end", i), 32'(busy), 32'd0);
        end

        // Back-to-back words: 3-cycle idle gap between frames
        frames.delete();
        rd0 = rd_cnt;
        @(negedge clk);
        for (int k = 0; k < 3; k++) fq.push_back(b2b[k]);
        wait_frames(3, FRAME * 6, ok);
        check("b2b_timeout", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        if (ok) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("b2b%0d_bits", k), 32'(frames[k].bits), 32'(model_frame(b2b[k])));
            check("b2b_gap01", 32'(frames[1].fall - frames[0].fall), 32'(FRAME + 3));
            check("b2b_gap12", 32'(frames[2].fall - frames[1].fall), 32'(FRAME + 3));
        end
        check("b2b_rd_count", 32'(rd_cnt - rd0), 32'd3);

        // Asynchronous reset in the middle of a data bit
        frames.delete();
        rd0 = rd_cnt;
        f0  = falls;
        @(negedge clk);
        fq.push_back(8'hef);
        fq.push_back(8'h3c);
        t = 0;
        while (falls == f0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("arst_start_seen", 32'(falls != f0), 32'd1);
        repeat (DIV * 5) @(negedge clk);
        check("arst_tx_before", 32'(tx), 32'd0);
        check("arst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_frames(1, FRAME * 3, ok);
        check("arst_timeout", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        if (ok) check("arst_next_bits", 32'(frames[0].bits), 32'(model_frame(8'h3c)));
        check("arst_frame_count", 32'(frames.size()), 32'd1);
        check("arst_rd_count", 32'(rd_cnt - rd0), 32'd2);

        // Full FIFO drained in order
        frames.delete();
        rd0  = rd_cnt;
        rde0 = rd_empty_cnt;
        @(negedge clk);
        for (int k = 1; k <= DEPTH; k++) fq.push_back(8'(k));
        wait_frames(DEPTH, FRAME * (DEPTH + 4), ok);
        check("full_timeout", 32'(ok), 32'd1);
        repeat (50) @(negedge clk);
        for (int k = 0; k < frames.size() && k < DEPTH; k++)
            check($sformatf("full%0d_bits", k), 32'(frames[k].bits), 32'(model_frame(8'(k + 1))));
        check("full_rd_count", 32'(rd_cnt - rd0), 32'(DEPTH));
        check("full_rd_empty", 32'(rd_empty_cnt - rde0), 32'd0);

        // Randomized traffic against the frame model
        frames.delete();
        exp_q.delete();
        rd0 = rd_cnt;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            t = 0;
            while (fq.size() >= DEPTH && t < 1000) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            fq.push_back(b);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_frames(24, FRAME * 30, ok);
        check("rand_timeout", 32'(ok), 32'd1);
        repeat (10) @(negedge clk);
        for (int k = 0; k < frames.size() && k < exp_q.size(); k++)
            check($sformatf("rand%0d_bits", k), 32'(frames[k].bits), 32'(model_frame(exp_q[k])));
        check("rand_rd_count", 32'(rd_cnt - rd0), 32'd24);

        check("rd_while_empty", 32'(rd_empty_cnt), 32'd0);
        check("rd_pulse_width", 32'(rd_double), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter that drains a byte FIFO. It sits on the read side of the existing `fifo` block: it pops a word whenever the FIFO is non-empty and serializes it onto the `tx` line as 8N1.
- Used by the d16 serial output path. The CPU or bus side writes the FIFO, and this block is the FIFO's only reader.

Parameters:
- FIFO_WIDTH, 8, data bits per frame; must match the FIFO word width.
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO read strobe; one-cycle pulse per word.
- fifo_data  input  FIFO_WIDTH  FIFO output data; valid the cycle after `fifo_rd`.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever a word is being fetched or sent.

Behaviour:
- Reset (`rst` low, asynchronous):
  - `tx`=1, `fifo_rd`=0, `busy`=0, state=IDLE.
  - Baud counter, bit counter and shift register are cleared.
  - Reset mid-frame aborts the frame and drives `tx` high immediately. The popped word is lost.
- States: IDLE, FETCH, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE:
  - `tx`=1.
  - If `fifo_empty`=0, go to FETCH.
- FETCH (1 cycle):
  - `fifo_rd`=1, then go to LOAD.
  - `fifo_rd` is never asserted in any other state. It is never asserted while `fifo_empty`=1 was sampled in IDLE.
- LOAD (1 cycle):
  - Latch `fifo_data` into the shift register.
  - Clear the baud counter.
  - Drive `tx`=0 at the edge leaving LOAD. `tx` therefore falls 2 clocks after the edge that raised `fifo_rd`.
- START: `tx`=0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - FIFO_WIDTH bits, LSB first, each held CLK_DIV cycles.
  - Shift right at each bit boundary.
  - The bit counter runs 0..FIFO_WIDTH-1.
- STOP: `tx`=1 for CLK_DIV cycles, then go to IDLE.
- Baud counter:
  - Width is $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1; the wrap marks a bit boundary.
  - No fractional division.
- busy: 1 in every state except IDLE.
- Frame length: (FIFO_WIDTH+2)·CLK_DIV cycles.
- Back-to-back words:
  - Minimum idle-high gap between the end of STOP and the next start bit is 3 cycles (IDLE, FETCH, LOAD).
- Changes on `fifo_empty` or `fifo_data` outside IDLE/LOAD are ignored.
- FIFO contract: registered read, with data presented the cycle after `rd`.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It sends even parity (XOR of data bits) for CLK_DIV cycles.
  - Frame = (FIFO_WIDTH+3)·CLK_DIV cycles.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Decomposition:
- Shared include `uart_defs.vh`:
  - State encoding localparams (IDLE..STOP, PARITY).
  - UART_IDLE_LEVEL=1.
  - Default CLK_DIV.
- Sub-module `uart_baud_gen`:
  - Inputs: clear input.
  - Outputs: one-cycle `tick` at the counter wrap.
  - Parameterized by CLK_DIV.
  - Reused later by a uart_rx.

Test Plan (CLK_DIV=4, with a `fifo` instance writer-side):
- Reset held, then released with FIFO empty -> `tx`=1, `busy`=0, and `fifo_rd` never pulses for 100 cycles.
- Write 8'h67 -> exactly one `fifo_rd` pulse. `tx` is low 2 cycles later. Sampled every 4 cycles, `tx` gives 0,1,1,1,0,0,1,1,0,1. `busy` drops 40 cycles after `tx` falls. `empty`=1 afterwards.
- Write 8'h4d, 8'hef, 8'h01 back-to-back -> three frames in order (LSB-first bits of each). Idle gap between frames is exactly 3 cycles. Exactly 3 `fifo_rd` pulses.
- Assert `rst` low mid-DATA of 8'hef -> `tx`=1 and `busy`=0 asynchronously. After release, the next FIFO word is sent cleanly, with no partial frame.
- Fill the FIFO to full (8 words 8'h01..8'h08) -> all 8 are transmitted in order. `fifo_rd` never pulses after `empty`=1.
- UART_TX_PARITY_EN defined, write 8'h67 -> parity bit 1 precedes the stop bit, and the frame is 44 cycles.
